game_ctrl: RTL and testbench

- Parametrised match controller for pong; successor to the fixed 9-point, fixed-speed game loop.
- Sits between the debounced buttons and the ball engine on `game_clk` (1000 Hz).
- Keeps score, times the freeze between points and games, and drives ball speed, ball reset and serve direction.
- Adds behaviour the previous loop lacked: configurable win score and delays, per-rally speed ramp on paddle hits, a pause toggle, and winner / serve-direction outputs.
- The ball engine is external; this block consumes its `out_left`, `out_right` and `hit` events.

---
 rtl/pong_pkg.sv | 29 ++
 rtl/game_ctrl_if.sv | 41 ++++
 rtl/freeze_timer.sv | 30 +++
 rtl/game_ctrl.sv | 175 +++++++++++++++++
 tb/tb_game_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// Shared definitions for the pong match controller.
//   - state_e     : match controller states
//   - DIR_LEFT/RIGHT : serve direction encodings
//   - DEF_SERVE_DELAY / DEF_END_DELAY : default freeze lengths in game_clk cycles
//   - timer_width : width of a down-counter able to hold the longer freeze
package pong_pkg;

    typedef enum logic [2:0] {
        ST_OVER   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_SERVE  = 3'd2,
        ST_PLAY   = 3'd3,
        ST_PAUSED = 3'd4
    } state_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam int DEF_SERVE_DELAY = 2000;
    localparam int DEF_END_DELAY   = 16383;

    // $clog2 of the larger delay, never narrower than one bit.
    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// Bundle between the button/ball-engine side and the match controller.
//   master (button + ball engine side): drives start, pause, hit, out_left,
//     out_right; receives score_p1, score_p2, speed, ball_reset, serve_dir,
//     game_over, winner, dbg_state.
//   slave (game_ctrl): the opposite directions.
// Event semantics: pause, hit, out_left and out_right are single-cycle pulses
// sampled on the rising edge of game_clk; start is a level. There is no
// back-pressure: every pulse is consumed or dropped in the cycle it appears.
// All slave outputs are registered.
interface game_ctrl_if
    import pong_pkg::*;
#(
    parameter int SCORE_W = 4,
    parameter int SPEED_W = 5
);
    logic               start;
    logic               pause;
    logic               hit;
    logic               out_left;
    logic               out_right;
    logic [SCORE_W-1:0] score_p1;
    logic [SCORE_W-1:0] score_p2;
    logic [SPEED_W-1:0] speed;
    logic               ball_reset;
    logic               serve_dir;
    logic               game_over;
    logic               winner;
    state_e             dbg_state;

    modport master (
        output start, pause, hit, out_left, out_right,
        input  score_p1, score_p2, speed, ball_reset, serve_dir,
               game_over, winner, dbg_state
    );

    modport slave (
        input  start, pause, hit, out_left, out_right,
        output score_p1, score_p2, speed, ball_reset, serve_dir,
               game_over, winner, dbg_state
    );
endinterface

// File: rtl/freeze_timer.sv
// Loadable down-counter timing the freeze between points and games.
//   i_clk      : clock
//   i_load     : load i_load_val (highest priority)
//   i_load_val : value to load
//   i_cut      : force expiry immediately (start button)
//   i_en       : count down while not expired
//   o_expired  : count reached zero, or cut asserted
// No reset of its own: the owner asserts i_load during reset.
module freeze_timer #(
    parameter int W = 14
) (
    input  logic         i_clk,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_cut,
    input  logic         i_en,
    output logic         o_expired
);
    logic [W-1:0] r_count;

    assign o_expired = i_cut | (r_count == '0);

    always_ff @(posedge i_clk) begin
        if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && !o_expired) begin
            r_count <= r_count - 1'b1;
        end
    end
endmodule

// File: rtl/game_ctrl.sv
// Pong match controller: keeps score, times the freezes between points and
// games, ramps ball speed on paddle hits and handles pause.
//   game_clk : game clock (1000 Hz)
//   reset    : synchronous, active-high
//   bus      : game_ctrl_if slave -- button/ball events in, score, speed,
//              ball_reset, serve_dir, game_over, winner, dbg_state out.
module game_ctrl
    import pong_pkg::*;
#(
    parameter int SCORE_W     = 4,
    parameter int WIN_SCORE   = 9,
    parameter int SPEED_W     = 5,
    parameter int SPEED_INIT  = 11,
    parameter int SPEED_STEP  = 1,
    parameter int SPEED_MAX   = 15,
    parameter int SERVE_DELAY = DEF_SERVE_DELAY,
    parameter int END_DELAY   = DEF_END_DELAY
) (
    input  logic        game_clk,
    input  logic        reset,
    game_ctrl_if.slave  bus
);
    localparam int TIMER_W = timer_width(SERVE_DELAY, END_DELAY);

    localparam logic [2:0] S_OVER   = ST_OVER;
    localparam logic [2:0] S_WAIT   = ST_WAIT;
    localparam logic [2:0] S_SERVE  = ST_SERVE;
    localparam logic [2:0] S_PLAY   = ST_PLAY;
    localparam logic [2:0] S_PAUSED = ST_PAUSED;

    logic [2:0]         r_state;
    logic [SCORE_W-1:0] r_p1;
    logic [SCORE_W-1:0] r_p2;
    logic [SPEED_W-1:0] r_speed;
    logic [SPEED_W-1:0] r_rally;
    logic               r_ball_reset;
    logic               r_serve_dir;
    logic               r_game_over;
    logic               r_winner;

    logic [2:0]         w_state_nxt;
    logic [SCORE_W-1:0] w_p1_nxt;
    logic [SCORE_W-1:0] w_p2_nxt;
    logic [SPEED_W-1:0] w_rally_nxt;
    logic               w_dir_nxt;
    logic               w_winner_nxt;

    logic               w_in_freeze;
    logic               w_expired;
    logic               w_point;
    logic               w_point_wins;
    logic               w_tmr_load;
    logic [TIMER_W-1:0] w_tmr_val;
    logic [SCORE_W:0]   w_p1_inc;
    logic [SCORE_W:0]   w_p2_inc;
    logic [SPEED_W:0]   w_rally_sum;
    logic [SPEED_W-1:0] w_rally_sat;

    // One bit wider than the scores/speed so the win compare and the speed
    // ramp never wrap.
    assign w_p1_inc    = {1'b0, r_p1} + (SCORE_W+1)'(1);
    assign w_p2_inc    = {1'b0, r_p2} + (SCORE_W+1)'(1);
    assign w_rally_sum = {1'b0, r_rally} + (SPEED_W+1)'(SPEED_STEP);
    assign w_rally_sat = (w_rally_sum > (SPEED_W+1)'(SPEED_MAX)) ?
                         SPEED_W'(SPEED_MAX) : w_rally_sum[SPEED_W-1:0];

    assign w_in_freeze = (r_state == S_OVER) || (r_state == S_WAIT);
    assign w_point     = (r_state == S_PLAY) && (bus.out_left || bus.out_right);
    // out_left takes precedence when both sides report a point.
    assign w_point_wins = bus.out_left ? (w_p1_inc == (SCORE_W+1)'(WIN_SCORE))
                                       : (w_p2_inc == (SCORE_W+1)'(WIN_SCORE));

    assign w_tmr_load = reset || w_point;
    assign w_tmr_val  = (reset || w_point_wins) ? TIMER_W'(END_DELAY - 1)
                                                : TIMER_W'(SERVE_DELAY - 1);

    freeze_timer #(.W(TIMER_W)) u_freeze_timer (
        .i_clk      (game_clk),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_cut      (bus.start),
        .i_en       (w_in_freeze),
        .o_expired  (w_expired)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_p1_nxt     = r_p1;
        w_p2_nxt     = r_p2;
        w_rally_nxt  = r_rally;
        w_dir_nxt    = r_serve_dir;
        w_winner_nxt = r_winner;
        case (r_state)
            S_OVER, S_WAIT: begin
                if (w_expired) begin
                    w_state_nxt = S_SERVE;
                    if (r_state == S_OVER) begin
                        w_p1_nxt = '0;
                        w_p2_nxt = '0;
                    end
                end
            end
            S_SERVE: begin
                w_state_nxt = S_PLAY;
                w_rally_nxt = SPEED_W'(SPEED_INIT);
            end
            S_PLAY: begin
                if (bus.out_left) begin
                    w_p1_nxt  = w_p1_inc[SCORE_W-1:0];
                    w_dir_nxt = DIR_LEFT;
                    if (w_point_wins) begin
                        w_state_nxt  = S_OVER;
                        w_winner_nxt = 1'b0;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end else if (bus.out_right) begin
                    w_p2_nxt  = w_p2_inc[SCORE_W-1:0];
                    w_dir_nxt = DIR_RIGHT;
                    if (w_point_wins) begin
                        w_state_nxt  = S_OVER;
                        w_winner_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end else if (bus.pause) begin
                    w_state_nxt = S_PAUSED;
                end else if (bus.hit) begin
                    w_rally_nxt = w_rally_sat;
                end
            end
            S_PAUSED: begin
                if (bus.pause) begin
                    w_state_nxt = S_PLAY;
                end
            end
            default: w_state_nxt = S_OVER;
        endcase
    end

    always_ff @(posedge game_clk) begin
        if (reset) begin
            r_state      <= S_OVER;
            r_p1         <= '0;
            r_p2         <= '0;
            r_speed      <= '0;
            r_rally      <= '0;
            r_ball_reset <= 1'b1;
            r_serve_dir  <= DIR_LEFT;
            r_game_over  <= 1'b1;
            r_winner     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_p1         <= w_p1_nxt;
            r_p2         <= w_p2_nxt;
            r_rally      <= w_rally_nxt;
            r_serve_dir  <= w_dir_nxt;
            r_winner     <= w_winner_nxt;
            // Outputs derive from the next state so they stay registered
            // and line up with the state they describe.
            r_speed      <= (w_state_nxt == S_PLAY) ? w_rally_nxt : '0;
            r_ball_reset <= (w_state_nxt == S_SERVE);
            r_game_over  <= (w_state_nxt == S_OVER);
        end
    end

    assign bus.score_p1   = r_p1;
    assign bus.score_p2   = r_p2;
    assign bus.speed      = r_speed;
    assign bus.ball_reset = r_ball_reset;
    assign bus.serve_dir  = r_serve_dir;
    assign bus.game_over  = r_game_over;
    assign bus.winner     = r_winner;
    assign bus.dbg_state  = state_e'(r_state);
endmodule

// File: tb/tb_game_ctrl.sv
module tb_game_ctrl;
    import pong_pkg::*;

    localparam int SCORE_W     = 4;
    localparam int SPEED_W     = 5;
    localparam int WIN_SCORE   = 3;
    localparam int SERVE_DELAY = 4;
    localparam int END_DELAY   = 8;
    localparam int SPEED_INIT  = 11;
    localparam int SPEED_STEP  = 2;
    localparam int SPEED_MAX   = 15;

    localparam int MD_OVER = 0, MD_WAIT = 1, MD_SERVE = 2, MD_PLAY = 3, MD_PAUSED = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    // reference model of the match, updated once per clock edge
    int m_mode, m_left, m_p1, m_p2, m_rally, m_speed;
    int m_br, m_dir, m_go, m_win;

    game_ctrl_if #(.SCORE_W(SCORE_W), .SPEED_W(SPEED_W)) bus ();

    game_ctrl #(
        .SCORE_W(SCORE_W), .WIN_SCORE(WIN_SCORE), .SPEED_W(SPEED_W),
        .SPEED_INIT(SPEED_INIT), .SPEED_STEP(SPEED_STEP), .SPEED_MAX(SPEED_MAX),
        .SERVE_DELAY(SERVE_DELAY), .END_DELAY(END_DELAY)
    ) dut (
        .game_clk (clk),
        .reset    (rst),
        .bus      (bus.slave)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- model ----------------
    task automatic model_edge();
        bit done;
        done = 1'b0;
        if (rst) begin
            m_mode = MD_OVER; m_left = END_DELAY - 1;
            m_p1 = 0; m_p2 = 0; m_rally = 0; m_speed = 0;
            m_br = 1; m_dir = 0; m_go = 1; m_win = 0;
            return;
        end
        case (m_mode)
            MD_OVER, MD_WAIT: begin
                if (bus.start || m_left == 0) begin
                    if (m_mode == MD_OVER) begin m_p1 = 0; m_p2 = 0; end
                    m_mode = MD_SERVE;
                end else begin
                    m_left = m_left - 1;
                end
            end
            MD_SERVE: begin m_mode = MD_PLAY; m_rally = SPEED_INIT; end
            MD_PLAY: begin
                if (bus.out_left || bus.out_right) begin
                    if (bus.out_left) begin m_p1++; m_dir = 0; done = (m_p1 == WIN_SCORE); end
                    else begin m_p2++; m_dir = 1; done = (m_p2 == WIN_SCORE); end
                    if (done) begin m_mode = MD_OVER; m_win = m_dir; m_left = END_DELAY - 1; end
                    else begin m_mode = MD_WAIT; m_left = SERVE_DELAY - 1; end
                end else if (bus.pause) begin
                    m_mode = MD_PAUSED;
                end else if (bus.hit) begin
                    m_rally = (m_rally + SPEED_STEP > SPEED_MAX) ? SPEED_MAX : m_rally + SPEED_STEP;
                end
            end
            MD_PAUSED: if (bus.pause) m_mode = MD_PLAY;
            default: m_mode = MD_OVER;
        endcase
        m_speed = (m_mode == MD_PLAY) ? m_rally : 0;
        m_br    = (m_mode == MD_SERVE) ? 1 : 0;
        m_go    = (m_mode == MD_OVER) ? 1 : 0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_in(input bit s, input bit p, input bit h, input bit l, input bit r);
        bus.start = s; bus.pause = p; bus.hit = h; bus.out_left = l; bus.out_right = r;
    endtask

    // one clock edge; outputs are sampled 1 time unit after it
    task automatic edge_step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [16:0] exp_v;
        logic [6:0]  exp_e;
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0);
        edge_step();
        edge_step();
        exp_v = {4'd0, 4'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        total++;
        if ({bus.score_p1, bus.score_p2, bus.speed, bus.ball_reset, bus.serve_dir,
             bus.game_over, bus.winner} !== exp_v) begin
            bad++;
            $display("FAIL reset_values got=%h exp=%h", {bus.score_p1, bus.score_p2, bus.speed,
                     bus.ball_reset, bus.serve_dir, bus.game_over, bus.winner}, exp_v);
        end
        rst = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            edge_step();
            exp_e = {(e == 8) ? 1'b1 : 1'b0, (e < 8) ? 1'b1 : 1'b0, (e >= 9) ? 5'd11 : 5'd0};
            total++;
            if ({bus.ball_reset, bus.game_over, bus.speed} !== exp_e) begin
                bad++;
                $display("FAIL release_edge%0d br/go/speed got=%b exp=%b", e,
                         {bus.ball_reset, bus.game_over, bus.speed}, exp_e);
            end
        end
        total++;
        if ({bus.score_p1, bus.score_p2} !== 8'h00) begin
            bad++;
            $display("FAIL release_scores got=%h exp=00", {bus.score_p1, bus.score_p2});
        end
    endtask

    task automatic test_hit_ramp();
        int exp_sp[3] = '{13, 15, 15};
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 1, 0, 0);
            edge_step();
            total++;
            if (bus.speed !== 5'(exp_sp[i])) begin
                bad++;
                $display("FAIL hit%0d speed got=%0d exp=%0d", i, bus.speed, exp_sp[i]);
            end
            set_in(0, 0, 0, 0, 0);
            edge_step();
        end
        set_in(0, 0, 0, 0, 1);
        edge_step();
        set_in(0, 0, 0, 0, 0);
        total++;
        if ({bus.score_p2, bus.speed, bus.serve_dir, bus.game_over} !== {4'd1, 5'd0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL out_right p2/speed/dir/go got=%0d/%0d/%0b/%0b exp=1/0/1/0",
                     bus.score_p2, bus.speed, bus.serve_dir, bus.game_over);
        end
        for (int e = 1; e <= 4; e++) begin
            edge_step();
            total++;
            if (bus.ball_reset !== ((e == 4) ? 1'b1 : 1'b0)) begin
                bad++;
                $display("FAIL wait_edge%0d ball_reset got=%0b exp=%0b", e, bus.ball_reset, (e == 4));
            end
        end
        edge_step();
        total++;
        if ({bus.speed, bus.ball_reset} !== {5'd11, 1'b0}) begin
            bad++;
            $display("FAIL reserve speed/br got=%0d/%0b exp=11/0", bus.speed, bus.ball_reset);
        end
    endtask

    task automatic test_start_cut();
        set_in(0, 0, 0, 0, 1);
        edge_step();
        set_in(1, 0, 0, 0, 0);
        edge_step();
        total++;
        if ({bus.ball_reset, bus.score_p2} !== {1'b1, 4'd2}) begin
            bad++;
            $display("FAIL start_cut br/p2 got=%0b/%0d exp=1/2", bus.ball_reset, bus.score_p2);
        end
        set_in(0, 0, 0, 0, 0);
        edge_step();
        total++;
        if ({bus.ball_reset, bus.speed} !== {1'b0, 5'd11}) begin
            bad++;
            $display("FAIL start_cut_play br/speed got=%0b/%0d exp=0/11", bus.ball_reset, bus.speed);
        end
    endtask

    task automatic recover();
        set_in(1, 0, 0, 0, 0);
        edge_step();
        set_in(0, 0, 0, 0, 0);
        edge_step();
    endtask

    task automatic test_simultaneous();
        set_in(0, 0, 0, 1, 1);
        edge_step();
        total++;
        if ({bus.score_p1, bus.score_p2, bus.serve_dir} !== {4'd1, 4'd2, 1'b0}) begin
            bad++;
            $display("FAIL both_out p1/p2/dir got=%0d/%0d/%0b exp=1/2/0",
                     bus.score_p1, bus.score_p2, bus.serve_dir);
        end
        recover();
        set_in(0, 0, 1, 0, 0);
        edge_step();
        total++;
        if (bus.speed !== 5'd13) begin
            bad++;
            $display("FAIL pre_hit speed got=%0d exp=13", bus.speed);
        end
        set_in(0, 0, 1, 1, 0);
        edge_step();
        total++;
        if ({bus.score_p1, bus.speed, bus.game_over} !== {4'd2, 5'd0, 1'b0}) begin
            bad++;
            $display("FAIL out_hit p1/speed/go got=%0d/%0d/%0b exp=2/0/0",
                     bus.score_p1, bus.speed, bus.game_over);
        end
        recover();
        total++;
        if (bus.speed !== 5'd11) begin
            bad++;
            $display("FAIL out_hit_serve speed got=%0d exp=11", bus.speed);
        end
    endtask

    task automatic test_win();
        set_in(0, 0, 0, 1, 0);
        edge_step();
        set_in(0, 0, 0, 0, 0);
        total++;
        if ({bus.score_p1, bus.game_over, bus.winner, bus.speed} !== {4'd3, 1'b1, 1'b0, 5'd0}) begin
            bad++;
            $display("FAIL win p1/go/winner/speed got=%0d/%0b/%0b/%0d exp=3/1/0/0",
                     bus.score_p1, bus.game_over, bus.winner, bus.speed);
        end
        for (int e = 1; e <= 7; e++) begin
            edge_step();
            total++;
            if ({bus.score_p1, bus.game_over, bus.ball_reset} !== {4'd3, 1'b1, 1'b0}) begin
                bad++;
                $display("FAIL over_hold%0d p1/go/br got=%0d/%0b/%0b exp=3/1/0", e,
                         bus.score_p1, bus.game_over, bus.ball_reset);
            end
        end
        edge_step();
        total++;
        if ({bus.ball_reset, bus.score_p1, bus.score_p2, bus.game_over} !== {1'b1, 4'd0, 4'd0, 1'b0}) begin
            bad++;
            $display("FAIL new_game br/p1/p2/go got=%0b/%0d/%0d/%0b exp=1/0/0/0",
                     bus.ball_reset, bus.score_p1, bus.score_p2, bus.game_over);
        end
        edge_step();
    endtask

    task automatic test_pause();
        set_in(0, 0, 1, 0, 0);
        edge_step();
        set_in(0, 1, 0, 0, 0);
        edge_step();
        total++;
        if (bus.speed !== 5'd0) begin
            bad++;
            $display("FAIL pause speed got=%0d exp=0", bus.speed);
        end
        set_in(0, 0, 0, 1, 0);
        edge_step();
        set_in(0, 0, 1, 0, 0);
        edge_step();
        total++;
        if ({bus.score_p1, bus.speed} !== {4'd0, 5'd0}) begin
            bad++;
            $display("FAIL paused_ignore p1/speed got=%0d/%0d exp=0/0", bus.score_p1, bus.speed);
        end
        set_in(0, 1, 0, 0, 0);
        edge_step();
        total++;
        if ({bus.score_p1, bus.speed} !== {4'd0, 5'd13}) begin
            bad++;
            $display("FAIL unpause p1/speed got=%0d/%0d exp=0/13", bus.score_p1, bus.speed);
        end
        edge_step();
        set_in(0, 0, 0, 0, 0);
        rst = 1'b1;
        edge_step();
        rst = 1'b0;
        total++;
        if ({bus.score_p1, bus.score_p2, bus.speed, bus.ball_reset, bus.serve_dir,
             bus.game_over, bus.winner} !== {4'd0, 4'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset_in_pause got=%h exp=%h", {bus.score_p1, bus.score_p2, bus.speed,
                     bus.ball_reset, bus.serve_dir, bus.game_over, bus.winner},
                     {4'd0, 4'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0});
        end
    endtask

    task automatic test_random();
        logic [16:0] obs, exp_v;
        int shown = 0;
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0);
        edge_step();
        rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 499) == 0);
            set_in($urandom_range(0, 19) == 0, $urandom_range(0, 14) == 0,
                   $urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0,
                   $urandom_range(0, 11) == 0);
            edge_step();
            obs   = {bus.score_p1, bus.score_p2, bus.speed, bus.ball_reset, bus.serve_dir,
                     bus.game_over, bus.winner};
            exp_v = {4'(m_p1), 4'(m_p2), 5'(m_speed), 1'(m_br), 1'(m_dir), 1'(m_go), 1'(m_win)};
            total++;
            if (obs !== exp_v) begin
                bad++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random cycle %0d p1,p2,speed,br,dir,go,win got=%h exp=%h", c, obs, exp_v);
                end
            end
        end
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0);
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        set_in(0, 0, 0, 0, 0);
        test_reset();
        test_hit_ramp();
        test_start_cut();
        test_simultaneous();
        test_win();
        test_pause();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
